// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, single-outstanding imem request
// tracking, stall hold buffer and the IF/ID pipeline register.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallD,
   input  logic        pcsrcD,
   input  logic        jumpD,
   input  logic [31:0] pcbranchD,
   input  logic [31:0] pcjumpD,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic        inst_ready,
   input  logic [31:0] inst_rdata,
   output logic [31:0] instrD,
   output logic [31:0] pcD,
   output logic [31:0] pcplus4D,
   output logic        validD,
   output logic        fetch_busy
);

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      HOLD = 2'd1,
      DROP = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] hold_q, hold_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pcd_q, pcd_d;
   logic [31:0] pcp4_q, pcp4_d;
   logic        valid_q, valid_d;

   logic        avail;
   logic        redirect;
   logic [31:0] word;
   logic [31:0] target;
   logic [31:0] pc_plus4;

   assign avail    = ((state_q == RUN) && inst_ready) || (state_q == HOLD);
   assign redirect = (pcsrcD || jumpD) && !stallD;
   assign target   = jumpD ? pcjumpD : pcbranchD;
   assign word     = (state_q == HOLD) ? hold_q : inst_rdata;
   assign pc_plus4 = pc_q + 32'd4;

   assign inst_req   = (state_q == RUN) && !rst;
   assign inst_addr  = pc_q;
   assign fetch_busy = !avail;
   assign instrD     = instr_q;
   assign pcD        = pcd_q;
   assign pcplus4D   = pcp4_q;
   assign validD     = valid_q;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      hold_d  = hold_q;
      instr_d = instr_q;
      pcd_d   = pcd_q;
      pcp4_d  = pcp4_q;
      valid_d = valid_q;
      if (redirect) begin
         pc_d    = target;
         instr_d = 32'd0;
         pcd_d   = 32'd0;
         pcp4_d  = 32'd0;
         valid_d = 1'b0;
         // An unanswered request (RUN or DROP) must still be swallowed
         state_d = (state_q != HOLD && !inst_ready) ? DROP : RUN;
      end else if (state_q == DROP) begin
         if (!stallD) begin
            instr_d = 32'd0;
            pcd_d   = 32'd0;
            pcp4_d  = 32'd0;
            valid_d = 1'b0;
         end
         if (inst_ready) state_d = RUN;
      end else if (stallD) begin
         if (state_q == RUN && inst_ready) begin
            hold_d  = inst_rdata;
            state_d = HOLD;
         end
      end else if (avail) begin
         instr_d = word;
         pcd_d   = pc_q;
         pcp4_d  = pc_plus4;
         valid_d = 1'b1;
         pc_d    = pc_plus4;
         state_d = RUN;
      end else begin
         instr_d = 32'd0;
         pcd_d   = 32'd0;
         pcp4_d  = 32'd0;
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         pc_q    <= RESET_PC;
         hold_q  <= 32'd0;
         instr_q <= 32'd0;
         pcd_q   <= 32'd0;
         pcp4_q  <= 32'd0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         hold_q  <= hold_d;
         instr_q <= instr_d;
         pcd_q   <= pcd_d;
         pcp4_q  <= pcp4_d;
         valid_q <= valid_d;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized traffic
// checked against a flag-based behavioural model of the fetch rules.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst, stallD, pcsrcD, jumpD, inst_ready;
   logic [31:0] pcbranchD, pcjumpD, inst_rdata;
   logic        inst_req, validD, fetch_busy;
   logic [31:0] inst_addr, instrD, pcD, pcplus4D;

   int total = 0;
   int bad   = 0;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   fetch_stage #(.RESET_PC(RST_PC)) dut (
      .clk(clk), .rst(rst), .stallD(stallD), .pcsrcD(pcsrcD),
      .jumpD(jumpD), .pcbranchD(pcbranchD), .pcjumpD(pcjumpD),
      .inst_req(inst_req), .inst_addr(inst_addr),
      .inst_ready(inst_ready), .inst_rdata(inst_rdata),
      .instrD(instrD), .pcD(pcD), .pcplus4D(pcplus4D),
      .validD(validD), .fetch_busy(fetch_busy)
   );

   always #5 clk = ~clk;

   // Model: pc, "late response to discard" flag, "word parked" flag.
   logic [31:0] m_pc, m_hw, m_instr, m_pcd, m_pcp4;
   logic        m_drop, m_held, m_valid;

   function automatic logic m_avail();
      return m_held || (!m_drop && inst_ready);
   endfunction

   function automatic logic m_req();
      return !rst && !m_drop && !m_held;
   endfunction

   task automatic set_in(input logic r, input logic st, input logic bs,
                         input logic jp, input logic [31:0] bt,
                         input logic [31:0] jt, input logic rd,
                         input logic [31:0] data);
      rst = r; stallD = st; pcsrcD = bs; jumpD = jp;
      pcbranchD = bt; pcjumpD = jt; inst_ready = rd; inst_rdata = data;
      #1;
   endtask

   task automatic bubble();
      m_instr = 0; m_pcd = 0; m_pcp4 = 0; m_valid = 0;
   endtask

   task automatic tick();
      logic take;
      logic [31:0] w;
      take = (pcsrcD || jumpD) && !stallD;
      w = m_held ? m_hw : inst_rdata;
      if (rst) begin
         m_pc = RST_PC; m_drop = 0; m_held = 0; m_hw = 0; bubble();
      end else if (take) begin
         m_drop = !m_held && !inst_ready;
         m_held = 0;
         m_pc = jumpD ? pcjumpD : pcbranchD;
         bubble();
      end else if (m_drop) begin
         if (!stallD) bubble();
         if (inst_ready) m_drop = 0;
      end else if (stallD) begin
         if (!m_held && inst_ready) begin
            m_held = 1; m_hw = inst_rdata;
         end
      end else if (m_avail()) begin
         m_instr = w; m_pcd = m_pc; m_pcp4 = m_pc + 4; m_valid = 1;
         m_pc = m_pc + 4; m_held = 0;
      end else begin
         bubble();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      set_in(1, 0, 0, 0, 0, 0, 0, 0);
      tick();
   endtask

   task automatic test_reset();
      set_in(1, 1, 1, 1, 32'h40, 32'h80, 1, 32'h1234);
      total++;
      if (inst_req !== 1'b0) begin
         bad++; $display("FAIL rst_req got=%b want=0", inst_req);
      end
      tick();
      total++;
      if (inst_addr !== RST_PC || validD !== 1'b0 || instrD !== 32'd0 ||
          pcD !== 32'd0 || pcplus4D !== 32'd0) begin
         bad++;
         $display("FAIL rst_state addr=%h v=%b i=%h pc=%h p4=%h want %h/0/0/0/0",
                  inst_addr, validD, instrD, pcD, pcplus4D, RST_PC);
      end
   endtask

   task automatic test_stream();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         set_in(0, 0, 0, 0, 0, 0, 1, m_pc);
         total++;
         if (fetch_busy !== 1'b0) begin
            bad++; $display("FAIL stream_busy%0d got=%b want=0", i, fetch_busy);
         end
         tick();
         total++;
         if (instrD !== 32'(4 * i) || validD !== 1'b1 ||
             pcplus4D !== 32'(4 * i + 4)) begin
            bad++;
            $display("FAIL stream%0d i=%h v=%b p4=%h want %h/1/%h",
                     i, instrD, validD, pcplus4D, 4 * i, 4 * i + 4);
         end
      end
   endtask

   task automatic test_wait();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         set_in(0, 0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF);
         total++;
         if (fetch_busy !== 1'b1 || inst_req !== 1'b1) begin
            bad++;
            $display("FAIL wait_busy%0d busy=%b req=%b want 1/1",
                     i, fetch_busy, inst_req);
         end
         tick();
         total++;
         if (validD !== 1'b0 || inst_addr !== 32'd0) begin
            bad++;
            $display("FAIL wait%0d v=%b addr=%h want 0/0", i, validD, inst_addr);
         end
      end
      set_in(0, 0, 0, 0, 0, 0, 1, 32'h0000_0abc);
      tick();
      total++;
      if (instrD !== 32'h0000_0abc || validD !== 1'b1) begin
         bad++;
         $display("FAIL wait_done i=%h v=%b want 00000abc/1", instrD, validD);
      end
   endtask

   task automatic test_stall_hold();
      do_reset();
      set_in(0, 1, 0, 0, 0, 0, 1, 32'h2402_0005);
      tick();
      set_in(0, 1, 0, 0, 0, 0, 0, 32'hFFFF_0000);
      total++;
      if (inst_req !== 1'b0 || fetch_busy !== 1'b0) begin
         bad++;
         $display("FAIL hold_state req=%b busy=%b want 0/0", inst_req, fetch_busy);
      end
      tick();
      total++;
      if (validD !== 1'b0 || inst_addr !== 32'd0) begin
         bad++;
         $display("FAIL hold_frozen v=%b addr=%h want 0/0", validD, inst_addr);
      end
      set_in(0, 0, 0, 0, 0, 0, 0, 32'hFFFF_0000);
      tick();
      total++;
      if (instrD !== 32'h2402_0005 || inst_addr !== 32'd4 || pcD !== 32'd0) begin
         bad++;
         $display("FAIL hold_release i=%h addr=%h pc=%h want 24020005/4/0",
                  instrD, inst_addr, pcD);
      end
   endtask

   task automatic test_branch_drop();
      do_reset();
      set_in(0, 0, 1, 0, 32'h40, 32'h0, 0, 0);
      tick();
      total++;
      if (inst_addr !== 32'h40 || validD !== 1'b0 || inst_req !== 1'b0) begin
         bad++;
         $display("FAIL drop_enter addr=%h v=%b req=%b want 40/0/0",
                  inst_addr, validD, inst_req);
      end
      set_in(0, 1, 0, 0, 0, 0, 1, 32'hBAD0_BAD0);
      tick();
      total++;
      if (instrD === 32'hBAD0_BAD0 || validD !== 1'b0 || inst_req !== 1'b1) begin
         bad++;
         $display("FAIL drop_late i=%h v=%b req=%b want !bad0bad0/0/1",
                  instrD, validD, inst_req);
      end
      set_in(0, 0, 0, 0, 0, 0, 1, 32'h0000_0040);
      tick();
      total++;
      if (instrD !== 32'h40 || pcD !== 32'h40 || validD !== 1'b1) begin
         bad++;
         $display("FAIL drop_resume i=%h pc=%h v=%b want 40/40/1",
                  instrD, pcD, validD);
      end
   endtask

   task automatic test_jump_priority();
      do_reset();
      set_in(0, 0, 0, 0, 0, 0, 1, 32'h1111);
      tick();
      set_in(0, 0, 1, 1, 32'h80, 32'h100, 1, 32'h2222);
      tick();
      total++;
      if (inst_addr !== 32'h100 || validD !== 1'b0 || instrD !== 32'd0) begin
         bad++;
         $display("FAIL jump_prio addr=%h v=%b i=%h want 100/0/0",
                  inst_addr, validD, instrD);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      set_in(0, 0, 0, 1, 0, 32'hFFFF_FFFC, 1, 32'h3333);
      tick();
      set_in(0, 0, 0, 0, 0, 0, 1, 32'h4444);
      tick();
      total++;
      if (inst_addr !== 32'd0 || pcD !== 32'hFFFF_FFFC || pcplus4D !== 32'd0) begin
         bad++;
         $display("FAIL wrap addr=%h pc=%h p4=%h want 0/fffffffc/0",
                  inst_addr, pcD, pcplus4D);
      end
   endtask

   task automatic test_reset_in_hold();
      do_reset();
      set_in(0, 0, 0, 0, 0, 0, 1, 32'h5);
      tick();
      set_in(0, 1, 0, 0, 0, 0, 1, 32'h6);
      tick();
      set_in(1, 1, 0, 0, 0, 0, 0, 32'h7);
      tick();
      set_in(0, 0, 0, 0, 0, 0, 0, 32'h8);
      total++;
      if (validD !== 1'b0 || inst_addr !== RST_PC || inst_req !== 1'b1) begin
         bad++;
         $display("FAIL rst_hold v=%b addr=%h req=%b want 0/%h/1",
                  validD, inst_addr, inst_req, RST_PC);
      end
   endtask

   task automatic test_random();
      logic r, st, bs, jp, rd;
      logic [31:0] bt, jt, dat;
      do_reset();
      for (int n = 0; n < 600; n++) begin
         r  = ($urandom_range(0, 49) == 0);
         st = ($urandom_range(0, 3) == 0);
         bs = ($urandom_range(0, 7) == 0);
         jp = ($urandom_range(0, 11) == 0);
         bt = {$urandom_range(0, 255), 2'b00};
         jt = {$urandom_range(0, 255), 2'b00} | 32'h1000;
         rd = !m_held && ($urandom_range(0, 2) != 0);
         dat = m_drop ? ($urandom() | 32'h8000_0000) : (m_pc ^ 32'h1357_9BDF);
         set_in(r, st, bs, jp, bt, jt, rd, dat);
         total++;
         if (inst_req !== m_req() || fetch_busy !== !m_avail()) begin
            bad++;
            $display("FAIL rnd_comb%0d req=%b busy=%b want %b/%b",
                     n, inst_req, fetch_busy, m_req(), !m_avail());
         end
         tick();
         total++;
         if (inst_addr !== m_pc || instrD !== m_instr || pcD !== m_pcd ||
             pcplus4D !== m_pcp4 || validD !== m_valid) begin
            bad++;
            $display("FAIL rnd_reg%0d a=%h i=%h pc=%h p4=%h v=%b want %h/%h/%h/%h/%b",
                     n, inst_addr, instrD, pcD, pcplus4D, validD,
                     m_pc, m_instr, m_pcd, m_pcp4, m_valid);
         end
      end
   endtask

   initial begin
      m_pc = RST_PC; m_drop = 0; m_held = 0; m_hw = 0;
      m_instr = 0; m_pcd = 0; m_pcp4 = 0; m_valid = 0;
      set_in(1, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      test_reset();
      test_stream();
      test_wait();
      test_stall_hold();
      test_branch_drop();
      test_jump_priority();
      test_wrap();
      test_reset_in_hold();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
